// File: rtl/ir_prefetch_queue.sv
// rtl/ir_prefetch_queue.sv - instruction register fed by a DEPTH-entry prefetch FIFO
module ir_prefetch_queue #(
    parameter int         TYPE_W       = 2,
    parameter int         CODE_W       = 3,
    parameter int         OPND_W       = 8,
    parameter int         DEPTH        = 4,
    parameter logic [2:0] DECODE_STATE = 3'b001,
    localparam int        INSTR_W      = TYPE_W + CODE_W + OPND_W,
    localparam int        CNT_W        = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] rom_data,
    input  logic               fetch_valid,
    output logic               fetch_ready,
    input  logic [2:0]         state,
    input  logic               flush,
    output logic [TYPE_W-1:0]  instruction_type,
    output logic [CODE_W-1:0]  instruction_code,
    output logic [OPND_W-1:0]  literal_or_address,
    output logic               ir_valid,
    output logic               decode_stall,
    output logic [CNT_W-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [INSTR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               push;
    logic               pop;
    logic               decode_req;
    logic [INSTR_W-1:0] head;

    assign fetch_ready = (count != CNT_W'(DEPTH)) && !reset;
    assign push        = fetch_valid && fetch_ready;
    assign decode_req  = (state == DECODE_STATE);
    // Pop only sees words pushed at earlier edges: no same-cycle bypass.
    assign pop         = decode_req && (count != '0);
    assign head        = mem[rd_ptr];

    // Storage has no reset; count and pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= rom_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            count              <= '0;
            ir_valid           <= 1'b0;
            decode_stall       <= 1'b0;
            instruction_type   <= '0;
            instruction_code   <= '0;
            literal_or_address <= '0;
        end else if (flush) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            ir_valid     <= 1'b0;
            decode_stall <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr             <= rd_ptr + 1'b1;
                instruction_type   <= head[INSTR_W-1 -: TYPE_W];
                instruction_code   <= head[OPND_W +: CODE_W];
                literal_or_address <= head[OPND_W-1:0];
            end
            if (decode_req) begin
                ir_valid <= pop;
            end
            count        <= count + CNT_W'(push) - CNT_W'(pop);
            decode_stall <= decode_req && !pop;
        end
    end

endmodule
